rca_sum_checker: RTL and testbench
==================================

RCA_SUM_CHECKER -- requirements
Module: rca_sum_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the operand/sum width.
REQ-002 The block SHALL have parameter NUM_VECTORS, default 256, the beats checked per run (1..65535).
REQ-003 Port clk SHALL be an input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit; reset is asynchronous and active-low.
REQ-005 Port start SHALL be an input, 1 bit, a run-request pulse.
REQ-006 Port in_valid SHALL be an input, 1 bit, marking a response beat from the adder under test.
REQ-007 Port in_ready SHALL be an output, 1 bit, indicating the checker accepts a beat.
REQ-008 Ports a, b SHALL be inputs, WIDTH bits each, the operands applied to the adder.
REQ-009 Port cin SHALL be an input, 1 bit, the applied carry-in.
REQ-010 Port sum SHALL be an input, WIDTH bits, the adder's sum result.
REQ-011 Port cout SHALL be an input, 1 bit, the adder's carry-out.
REQ-012 Port mismatch SHALL be an output, 1 bit, a one-cycle pulse per failing beat.
REQ-013 Port vec_count SHALL be an output, 16 bits, the number of beats accepted this run.
REQ-014 Port err_count SHALL be an output, 16 bits, the number of failing beats this run.
REQ-015 Ports first_err_a and first_err_b SHALL be outputs, WIDTH bits each, the operands of the first failing beat.
REQ-016 Port done SHALL be an output, 1 bit; pass SHALL be an output, 1 bit.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE -> RUN on start; this clears vec_count, err_count, first_err_a, first_err_b and the first-error flag.
REQ-019 in_ready SHALL be 1 only in RUN; a beat is accepted on an edge where in_valid and in_ready are both 1.
REQ-020 Beats with in_valid=0, or arriving outside RUN, SHALL be ignored and SHALL have no effect.
REQ-021 An accepted beat SHALL be registered into stage 1 at its accept edge N.
REQ-022 The expected result is {cout_exp,sum_exp} = a + b + cin, computed at WIDTH+1 bits with no truncation.
REQ-023 A beat fails if sum differs from sum_exp or cout differs from cout_exp.
REQ-024 For a failing beat, at edge N+1: mismatch=1 for one cycle and err_count increments.
REQ-025 vec_count SHALL increment at the accept edge N.
REQ-026 Both counters SHALL saturate at 16'hFFFF.
REQ-027 first_err_a and first_err_b SHALL capture only the first failing beat of a run and then hold.
REQ-028 RUN -> DRAIN on the edge that accepts beat number NUM_VECTORS; in_ready SHALL be 0 from that edge on.
REQ-029 DRAIN -> DONE after one cycle, so the last beat's check is complete.
REQ-030 In DONE: done=1, and pass=1 iff err_count==0.
REQ-031 start in DONE SHALL restart the run exactly as in REQ-018.
REQ-032 start in RUN or DRAIN SHALL be ignored.

Reset
REQ-033 While rst_n=0, all of the following SHALL be 0, asynchronously: state (IDLE), stage-1 registers, in_ready, mismatch, vec_count, err_count, first_err_a, first_err_b, done, pass.
REQ-034 Reset mid-run SHALL abort the run with no partial result retained.
REQ-035 Reset deassertion SHALL take effect at the next clk edge.

Structure
REQ-036 Shared package rca_pkg SHALL hold the FSM state encoding and the defaults RCA_WIDTH=16 and RCA_NUM_VECTORS=256.
REQ-037 The expected-sum computation SHALL be one sub-module, rca_ref_model (combinational WIDTH+1-bit adder), instantiated once.
REQ-038 The adder under test SHALL NOT be instantiated inside this block.

Verification
REQ-039 Clean run: NUM_VECTORS=4, beats a=b=0..3 with cin=0 and correct sums -> done=1, pass=1, vec_count=4, err_count=0, mismatch never high.
REQ-040 Injected error: beat a=16'h0005, b=16'h0003, cin=0, sum=16'h0009 -> mismatch pulse at N+1, err_count=1, first_err_a=5, first_err_b=3, pass=0.
REQ-041 Carry boundary: a=16'hFFFF, b=16'h0001, cin=1, sum=16'h0001, cout=1 -> pass; the same beat with cout=0 -> mismatch.
REQ-042 Backpressure: in_valid held high after beat NUM_VECTORS -> in_ready=0, and vec_count stays at NUM_VECTORS.
REQ-043 Reset mid-run: rst_n low after 2 of 4 beats -> all outputs 0 immediately; a new start then runs cleanly from vec_count=0.
REQ-044 Restart from DONE: after a failing run, start -> err_count=0, first_err_a=0, first_err_b=0, done=0 on the next cycle.

Source files
------------

// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared FSM encoding, default sizes and counter helper for the sum checker
package rca_pkg;

  localparam int RCA_WIDTH       = 16;
  localparam int RCA_NUM_VECTORS = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rca_state_e;

  // Counters stick at all-ones rather than wrapping back to a misleading small value.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/rca_ref_model.sv
// rtl/rca_ref_model.sv - combinational WIDTH+1-bit reference adder producing {cout,sum}
module rca_ref_model
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   result
);

  assign result = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/rca_sum_checker.sv
// rtl/rca_sum_checker.sv - checks a stream of adder responses against a reference sum, counting beats and failures
module rca_sum_checker
  import rca_pkg::*;
#(
  parameter int WIDTH       = RCA_WIDTH,
  parameter int NUM_VECTORS = RCA_NUM_VECTORS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             mismatch,
  output logic [15:0]      vec_count,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic             done,
  output logic             pass
);

  localparam logic [15:0] LAST_BEAT = 16'(NUM_VECTORS - 1);

  rca_state_e state;
  rca_state_e state_nxt;

  logic             accept;
  logic             restart;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic [WIDTH-1:0] s1_sum;
  logic             s1_cout;
  logic [WIDTH:0]   s1_exp;
  logic             s1_fail;
  logic             first_seen;

  assign accept  = in_valid && (state == ST_RUN);
  assign restart = start && ((state == ST_IDLE) || (state == ST_DONE));

  rca_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a      (s1_a),
    .b      (s1_b),
    .cin    (s1_cin),
    .result (s1_exp)
  );

  assign s1_fail = s1_valid && ({s1_cout, s1_sum} != s1_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        if (accept && (vec_count == LAST_BEAT)) state_nxt = ST_DRAIN;
      end
      // One extra cycle lets the final beat's stage-1 check land before DONE.
      ST_DRAIN: begin
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        pass = (err_count == 16'd0);
        if (start) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_cin      <= 1'b0;
      s1_sum      <= '0;
      s1_cout     <= 1'b0;
      mismatch    <= 1'b0;
      vec_count   <= 16'd0;
      err_count   <= 16'd0;
      first_err_a <= '0;
      first_err_b <= '0;
      first_seen  <= 1'b0;
    end else if (restart) begin
      s1_valid    <= 1'b0;
      mismatch    <= 1'b0;
      vec_count   <= 16'd0;
      err_count   <= 16'd0;
      first_err_a <= '0;
      first_err_b <= '0;
      first_seen  <= 1'b0;
    end else begin
      s1_valid <= accept;
      mismatch <= s1_fail;
      if (accept) begin
        s1_a      <= a;
        s1_b      <= b;
        s1_cin    <= cin;
        s1_sum    <= sum;
        s1_cout   <= cout;
        vec_count <= sat_inc16(vec_count);
      end
      if (s1_fail) begin
        err_count <= sat_inc16(err_count);
        if (!first_seen) begin
          first_err_a <= s1_a;
          first_err_b <= s1_b;
          first_seen  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rca_sum_checker.sv
// tb/tb_rca_sum_checker.sv - directed table-driven bench for rca_sum_checker with NUM_VECTORS=4
module tb_rca_sum_checker;

  localparam int WIDTH = 16;
  localparam int NV    = 4;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             start    = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a        = '0;
  logic [WIDTH-1:0] b        = '0;
  logic             cin      = 1'b0;
  logic [WIDTH-1:0] sum      = '0;
  logic             cout     = 1'b0;
  logic             in_ready;
  logic             mismatch;
  logic [15:0]      vec_count;
  logic [15:0]      err_count;
  logic [WIDTH-1:0] first_err_a;
  logic [WIDTH-1:0] first_err_b;
  logic             done;
  logic             pass;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        exp_mis;
  } beat_t;

  beat_t tbl[8];

  rca_sum_checker #(.WIDTH(WIDTH), .NUM_VECTORS(NV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sum         (sum),
    .cout        (cout),
    .mismatch    (mismatch),
    .vec_count   (vec_count),
    .err_count   (err_count),
    .first_err_a (first_err_a),
    .first_err_b (first_err_b),
    .done        (done),
    .pass        (pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " in_ready"},    32'(in_ready),    32'd0);
    chk({tag, " mismatch"},    32'(mismatch),    32'd0);
    chk({tag, " vec_count"},   32'(vec_count),   32'd0);
    chk({tag, " err_count"},   32'(err_count),   32'd0);
    chk({tag, " first_err_a"}, 32'(first_err_a), 32'd0);
    chk({tag, " first_err_b"}, 32'(first_err_b), 32'd0);
    chk({tag, " done"},        32'(done),        32'd0);
    chk({tag, " pass"},        32'(pass),        32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the check edge N+1.
  task automatic apply_beat(input beat_t v, input int idx);
    in_valid = 1'b1;
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
    sum      = v.sum;
    cout     = v.cout;
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("beat%0d vec_count", idx), 32'(vec_count), 32'(idx + 1));
    chk($sformatf("beat%0d mismatch@N", idx), 32'(mismatch), 32'd0);
    if (idx == NV - 1) chk($sformatf("beat%0d in_ready after last", idx), 32'(in_ready), 32'd0);
    @(negedge clk);
    chk($sformatf("beat%0d mismatch@N+1", idx), 32'(mismatch), 32'(v.exp_mis));
  endtask

  initial begin
    tbl[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    tbl[2] = '{16'h0002, 16'h0002, 1'b0, 16'h0004, 1'b0, 1'b0};
    tbl[3] = '{16'h0003, 16'h0003, 1'b0, 16'h0006, 1'b0, 1'b0};
    tbl[4] = '{16'h0005, 16'h0003, 1'b0, 16'h0009, 1'b0, 1'b1};
    tbl[5] = '{16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b0};
    tbl[6] = '{16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0};

    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Beats offered while idle must be ignored.
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle in_ready", 32'(in_ready), 32'd0);
    chk("idle vec_count", 32'(vec_count), 32'd0);

    // Run 1: clean; run 2: two failing beats and a carry boundary pass.
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      chk($sformatf("run%0d start vec_count", r), 32'(vec_count), 32'd0);
      chk($sformatf("run%0d in_ready", r), 32'(in_ready), 32'd1);
      for (int i = 0; i < NV; i++) apply_beat(tbl[r*NV + i], i);
      chk($sformatf("run%0d done", r), 32'(done), 32'd1);
      chk($sformatf("run%0d vec_count", r), 32'(vec_count), 32'd4);
      chk($sformatf("run%0d err_count", r), 32'(err_count), (r == 0) ? 32'd0 : 32'd2);
      chk($sformatf("run%0d pass", r), 32'(pass), (r == 0) ? 32'd1 : 32'd0);
      chk($sformatf("run%0d first_err_a", r), 32'(first_err_a), (r == 0) ? 32'd0 : 32'd5);
      chk($sformatf("run%0d first_err_b", r), 32'(first_err_b), (r == 0) ? 32'd0 : 32'd3);
    end

    // Restart from a failed DONE clears the result on the next cycle.
    pulse_start();
    chk("restart err_count", 32'(err_count), 32'd0);
    chk("restart first_err_a", 32'(first_err_a), 32'd0);
    chk("restart first_err_b", 32'(first_err_b), 32'd0);
    chk("restart done", 32'(done), 32'd0);
    chk("restart vec_count", 32'(vec_count), 32'd0);

    // Backpressure: in_valid held high past the last beat.
    in_valid = 1'b1;
    a = 16'h0001; b = 16'h0001; cin = 1'b0; sum = 16'h0002; cout = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp vec_count after 3", 32'(vec_count), 32'd3);
    chk("bp in_ready after 3", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp vec_count after 4", 32'(vec_count), 32'd4);
    chk("bp in_ready after 4", 32'(in_ready), 32'd0);
    repeat (4) @(negedge clk);
    chk("bp vec_count held", 32'(vec_count), 32'd4);
    chk("bp done", 32'(done), 32'd1);
    chk("bp pass", 32'(pass), 32'd1);
    chk("bp mismatch", 32'(mismatch), 32'd0);
    in_valid = 1'b0;

    // Reset mid-run after one failing and one good beat.
    pulse_start();
    apply_beat(tbl[4], 0);
    apply_beat(tbl[2], 1);
    chk("midrun err_count", 32'(err_count), 32'd1);
    chk("midrun first_err_a", 32'(first_err_a), 32'd5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start in RUN ignored vec_count", 32'(vec_count), 32'd2);
    chk("start in RUN ignored in_ready", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("after reset");
    pulse_start();
    for (int i = 0; i < NV; i++) apply_beat(tbl[i], i);
    chk("post-reset done", 32'(done), 32'd1);
    chk("post-reset pass", 32'(pass), 32'd1);
    chk("post-reset vec_count", 32'(vec_count), 32'd4);
    chk("post-reset err_count", 32'(err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
